// File: rtl/accu_half_sched.sv
// accu_half_sched
//   Round-robin scheduler that shares one external half-precision accumulator
//   between NREQ requesters. A granted job of req_len FP16 elements is
//   streamed into the accumulator. The first element restarts it through
//   acc_n. After the accumulator pipeline has drained, the FP16 sum is
//   returned on res_data, tagged with the requester index on res_id.
//
// Ports
//   clock, resetn          rising-edge clock, asynchronous active-low reset
//   req_valid  [NREQ]      job pending per requester (sampled in IDLE only)
//   req_len    [NREQ*LENW] job length per requester (sampled at grant)
//   req_dvalid [NREQ]      element present per requester
//   req_data   [NREQ*16]   FP16 element per requester
//   req_dready [NREQ]      one-hot accept for the granted requester while streaming
//   acc_x, acc_n           registered element / restart to the accumulator
//   acc_r                  accumulator running sum
//   res_valid/data/id      held result, released by res_ready
//   busy                   high whenever not IDLE
module accu_half_sched #(
  parameter int NREQ    = 2,
  parameter int IDW     = 1,
  parameter int LENW    = 8,
  parameter int ACC_LAT = 3
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*LENW-1:0] req_len,
  input  logic [NREQ-1:0]      req_dvalid,
  input  logic [NREQ*16-1:0]   req_data,
  output logic [NREQ-1:0]      req_dready,
  output logic [15:0]          acc_x,
  output logic                 acc_n,
  input  logic [15:0]          acc_r,
  output logic                 res_valid,
  output logic [15:0]          res_data,
  output logic [IDW-1:0]       res_id,
  input  logic                 res_ready,
  output logic                 busy
);

  localparam int WW = (ACC_LAT < 2) ? 1 : $clog2(ACC_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_RESULT} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_gid;
  logic [LENW-1:0] r_len;
  logic [LENW-1:0] r_cnt;
  logic [WW-1:0]   r_wait;
  logic [15:0]     r_acc_x;
  logic            r_acc_n;
  logic            r_res_valid;
  logic [15:0]     r_res_data;
  logic [IDW-1:0]  r_res_id;

  logic            w_gnt;
  logic [IDW-1:0]  w_gnt_id;
  logic [LENW-1:0] w_gnt_len;
  logic            w_hs;
  logic            w_last;
  logic [15:0]     w_gdata;

  // First requester with req_valid set, searching upward from r_ptr and wrapping.
  always_comb begin
    w_gnt    = 1'b0;
    w_gnt_id = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!w_gnt && req_valid[(32'(r_ptr) + k) % 32'(NREQ)]) begin
        w_gnt    = 1'b1;
        w_gnt_id = IDW'((32'(r_ptr) + k) % 32'(NREQ));
      end
    end
  end

  assign w_gnt_len = req_len[w_gnt_id*LENW +: LENW];
  assign w_gdata   = req_data[r_gid*16 +: 16];
  assign w_hs      = (r_state == S_STREAM) && req_dvalid[r_gid];
  assign w_last    = w_hs && (r_cnt == r_len - 1'b1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_gnt) w_next = (w_gnt_len != '0) ? S_STREAM : S_RESULT;
      S_STREAM: if (w_last) w_next = S_DRAIN;
      S_DRAIN:  if (r_wait == '0) w_next = S_RESULT;
      S_RESULT: if (res_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ptr       <= '0;
      r_gid       <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_wait      <= '0;
      r_acc_x     <= '0;
      r_acc_n     <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
    end else begin
      // Idle cycles feed +0 to the accumulator.
      r_acc_x <= '0;
      r_acc_n <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt) begin
            r_gid <= w_gnt_id;
            r_len <= w_gnt_len;
            r_cnt <= '0;
            r_ptr <= IDW'((32'(w_gnt_id) + 1) % 32'(NREQ));
            if (w_gnt_len == '0) begin
              r_res_valid <= 1'b1;
              r_res_data  <= '0;
              r_res_id    <= w_gnt_id;
            end
          end
        end
        S_STREAM: begin
          if (w_hs) begin
            r_acc_x <= w_gdata;
            r_acc_n <= (r_cnt == '0);
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) r_wait <= WW'(ACC_LAT);
          end
        end
        S_DRAIN: begin
          // The final element leaves acc_x one edge after its accept, so the
          // sum is captured once the counter has already reached zero.
          if (r_wait == '0) begin
            r_res_valid <= 1'b1;
            r_res_data  <= acc_r;
            r_res_id    <= r_gid;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        S_RESULT: begin
          if (res_ready) r_res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_dready = (r_state == S_STREAM) ? (NREQ'(1) << r_gid) : '0;
  assign acc_x      = r_acc_x;
  assign acc_n      = r_acc_n;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_id     = r_res_id;
  assign busy       = (r_state != S_IDLE);

endmodule
